// File: rtl/mvm_arb_pkg.sv
// Shared types for the two-requester matrix-vector engine arbiter.
package mvm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef logic req_id_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mvm_arb_pick.sv
// Combinational 2-way grant picker.
// MVM_ARB_FIXED_PRI_EN defined: requester 0 always wins a tie.
// MVM_ARB_FIXED_PRI_EN undefined: a tie goes to the requester that is not 'last'.
module mvm_arb_pick
  import mvm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output req_id_t    gnt_id,
  output logic       gnt_any
);

`ifdef MVM_ARB_FIXED_PRI_EN
  logic unused_last;
  assign unused_last = last;

  // Fixed priority: requester 0 first, requester 1 only when 0 is idle.
  always_comb begin
    gnt_any = |req;
    gnt_id  = req[0] ? 1'b0 : 1'b1;
  end
`else
  // Round-robin: a tie alternates away from the previous frame's owner.
  always_comb begin
    gnt_any = |req;
    if (&req) begin
      gnt_id = ~last;
    end else begin
      gnt_id = req[1] ? 1'b1 : 1'b0;
    end
  end
`endif

endmodule

// File: rtl/mvm_arbiter.sv
// Frame-granular arbiter sharing one matrix-vector layer engine between two
// requesters: the owner streams N words into the engine, then receives M
// words back, before the grant is re-arbitrated in a single IDLE cycle.
// Build option: MVM_ARB_FIXED_PRI_EN selects fixed priority instead of
// round-robin tie breaking.
module mvm_arbiter
  import mvm_arb_pkg::*;
#(
  parameter int T = 8,
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_valid_0,
  output logic         s_ready_0,
  input  logic [T-1:0] data_in_0,
  input  logic         s_valid_1,
  output logic         s_ready_1,
  input  logic [T-1:0] data_in_1,
  output logic         m_valid_0,
  input  logic         m_ready_0,
  output logic [T-1:0] data_out_0,
  output logic         m_valid_1,
  input  logic         m_ready_1,
  output logic [T-1:0] data_out_1,
  output logic         e_s_valid,
  input  logic         e_s_ready,
  output logic [T-1:0] e_data_in,
  input  logic         e_m_valid,
  output logic         e_m_ready,
  input  logic [T-1:0] e_data_out,
  output logic         busy,
  output logic         owner
);

  // Counters hold values up to max(N,M) so they never wrap inside a frame.
  localparam int CW = $clog2(max2(N, M) + 1);
  localparam logic [CW-1:0] N_LAST = CW'(N - 1);
  localparam logic [CW-1:0] M_LAST = CW'(M - 1);

  state_t        state;
  req_id_t       last_owner;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  req_id_t       gnt_id;
  logic          gnt_any;
  logic          in_xfer;
  logic          out_xfer;

  mvm_arb_pick u_pick (
    .req     ({s_valid_1, s_valid_0}),
    .last    (last_owner),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  // Pass-through steering: only the owner is connected to the engine, and
  // only in the phase that matches the direction of traffic.
  always_comb begin
    s_ready_0  = 1'b0;
    s_ready_1  = 1'b0;
    m_valid_0  = 1'b0;
    m_valid_1  = 1'b0;
    data_out_0 = '0;
    data_out_1 = '0;
    e_s_valid  = 1'b0;
    e_data_in  = '0;
    e_m_ready  = 1'b0;
    if (state == LOAD) begin
      if (owner == 1'b0) begin
        e_s_valid = s_valid_0;
        e_data_in = data_in_0;
        s_ready_0 = e_s_ready;
      end else begin
        e_s_valid = s_valid_1;
        e_data_in = data_in_1;
        s_ready_1 = e_s_ready;
      end
    end
    if (state == DRAIN) begin
      if (owner == 1'b0) begin
        m_valid_0  = e_m_valid;
        data_out_0 = e_data_out;
        e_m_ready  = m_ready_0;
      end else begin
        m_valid_1  = e_m_valid;
        data_out_1 = e_data_out;
        e_m_ready  = m_ready_1;
      end
    end
  end

  assign in_xfer  = e_s_valid & e_s_ready;
  assign out_xfer = e_m_valid & e_m_ready;
  assign busy     = (state != IDLE);

  // Frame FSM: arbitrate in IDLE, count N inputs in LOAD, M outputs in DRAIN.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      in_cnt     <= '0;
      out_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            owner <= gnt_id;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (in_xfer) begin
            in_cnt <= in_cnt + CW'(1);
            if (in_cnt == N_LAST) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            if (out_cnt == M_LAST) begin
              last_owner <= owner;
              in_cnt     <= '0;
              out_cnt    <= '0;
              state      <= IDLE;
            end else begin
              out_cnt <= out_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_arbiter.sv
// Self-checking bench for mvm_arbiter with a behavioural engine model,
// queue-driven requester sources and an expected/observed scoreboard.
module tb_mvm_arbiter;
  import mvm_arb_pkg::*;

  localparam int T = 8;
  localparam int N = 2;
  localparam int M = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic         s_valid_0, s_ready_0, s_valid_1, s_ready_1;
  logic [T-1:0] data_in_0, data_in_1;
  logic         m_valid_0, m_valid_1;
  logic         m_ready_0, m_ready_1;
  logic [T-1:0] data_out_0, data_out_1;
  logic         e_s_valid, e_s_ready, e_m_valid, e_m_ready;
  logic [T-1:0] e_data_in, e_data_out;
  logic         busy, owner;

  // Bench-controlled knobs
  logic         rdy0 = 1'b1;
  logic         rdy1 = 1'b1;
  logic         spur = 1'b0;
  logic [T-1:0] spur_data = 8'hEE;
  logic         eng_in_rdy = 1'b1;

  // Requester sources and engine response memory
  logic [T-1:0] src0 [0:31];
  logic [T-1:0] src1 [0:31];
  logic [T-1:0] resp [0:63];
  int src0_n = 0, src0_rd = 0, src1_n = 0, src1_rd = 0;
  int resp_wr = 0, resp_rd = 0, eng_in_cnt = 0, eng_out_left = 0;

  // Scoreboard queues
  logic [T-1:0] exp_eng[$], exp_out0[$], exp_out1[$];
  logic [T-1:0] obs_eng[$], obs_out0[$], obs_out1[$];

  int checks = 0;
  int errors = 0;

  assign s_valid_0  = (src0_rd < src0_n);
  assign data_in_0  = src0[src0_rd];
  assign s_valid_1  = (src1_rd < src1_n);
  assign data_in_1  = src1[src1_rd];
  assign m_ready_0  = rdy0;
  assign m_ready_1  = rdy1;
  assign e_s_ready  = eng_in_rdy;
  assign e_m_valid  = (eng_out_left > 0) || spur;
  assign e_data_out = (eng_out_left > 0) ? resp[resp_rd] : spur_data;

  mvm_arbiter #(.T(T), .N(N), .M(M)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid_0(s_valid_0), .s_ready_0(s_ready_0), .data_in_0(data_in_0),
    .s_valid_1(s_valid_1), .s_ready_1(s_ready_1), .data_in_1(data_in_1),
    .m_valid_0(m_valid_0), .m_ready_0(m_ready_0), .data_out_0(data_out_0),
    .m_valid_1(m_valid_1), .m_ready_1(m_ready_1), .data_out_1(data_out_1),
    .e_s_valid(e_s_valid), .e_s_ready(e_s_ready), .e_data_in(e_data_in),
    .e_m_valid(e_m_valid), .e_m_ready(e_m_ready), .e_data_out(e_data_out),
    .busy(busy), .owner(owner)
  );

  // Sources advance on handshake; engine collects N words then emits M.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src0_rd      <= src0_n;
      src1_rd      <= src1_n;
      eng_in_cnt   <= 0;
      eng_out_left <= 0;
      resp_rd      <= resp_wr;
    end else begin
      if (s_valid_0 && s_ready_0) src0_rd <= src0_rd + 1;
      if (s_valid_1 && s_ready_1) src1_rd <= src1_rd + 1;
      if (e_s_valid && e_s_ready) begin
        if (eng_in_cnt == N - 1) begin
          eng_in_cnt   <= 0;
          eng_out_left <= M;
        end else begin
          eng_in_cnt <= eng_in_cnt + 1;
        end
      end
      if (e_m_valid && e_m_ready && eng_out_left > 0) begin
        eng_out_left <= eng_out_left - 1;
        resp_rd      <= resp_rd + 1;
      end
    end
  end

  // Monitor: record every completed transfer
  always @(posedge clk) begin
    if (reset_n) begin
      if (e_s_valid && e_s_ready) obs_eng.push_back(e_data_in);
      if (m_valid_0 && m_ready_0) obs_out0.push_back(data_out_0);
      if (m_valid_1 && m_ready_1) obs_out1.push_back(data_out_1);
    end
  end

  task automatic clear_sb();
    exp_eng.delete(); exp_out0.delete(); exp_out1.delete();
    obs_eng.delete(); obs_out0.delete(); obs_out1.delete();
  endtask

  task automatic load0(input logic [T-1:0] w);
    src0[src0_n] = w;
    src0_n++;
  endtask

  task automatic load1(input logic [T-1:0] w);
    src1[src1_n] = w;
    src1_n++;
  endtask

  // Expected traffic of one frame, called in the order frames get served
  task automatic add_service(input int k, input logic [T-1:0] w0, input logic [T-1:0] w1,
                             input logic [T-1:0] r0, input logic [T-1:0] r1);
    exp_eng.push_back(w0);
    exp_eng.push_back(w1);
    resp[resp_wr]     = r0;
    resp[resp_wr + 1] = r1;
    resp_wr += 2;
    if (k == 0) begin
      exp_out0.push_back(r0); exp_out0.push_back(r1);
    end else begin
      exp_out1.push_back(r0); exp_out1.push_back(r1);
    end
  endtask

  task automatic wait_outputs(input int total, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((obs_out0.size() + obs_out1.size()) >= total && !busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    spur = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, owner, s_ready_0, s_ready_1, m_valid_0, m_valid_1, e_s_valid, e_m_ready} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000000",
               {busy, owner, s_ready_0, s_ready_1, m_valid_0, m_valid_1, e_s_valid, e_m_ready});
    end
    checks++;
    if (dut.last_owner !== 1'b1) begin
      errors++; $display("FAIL reset_last_owner got %b want 1", dut.last_owner);
    end
    checks++;
    if (dut.in_cnt !== 2'd0 || dut.out_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", dut.in_cnt, dut.out_cnt);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || e_m_ready !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b e_m_ready=%b want 0/0", busy, e_m_ready);
    end
    spur = 1'b0;
  endtask

  task automatic test_single();
    logic [T-1:0] e, o;
    int nout = 0;
    bit want_idle = 1'b0, done = 1'b0;
    clear_sb();
    @(posedge clk); #1;
    load0(8'h05); load0(8'h03);
    add_service(0, 8'h05, 8'h03, 8'h11, 8'h22);
    @(negedge clk);
    checks++;
    if (e_s_valid !== 1'b0 || busy !== 1'b0 || s_ready_0 !== 1'b0) begin
      errors++; $display("FAIL single_idle_cycle e_s_valid=%b busy=%b s_ready_0=%b want 0/0/0",
                         e_s_valid, busy, s_ready_0);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || owner !== 1'b0 || e_s_valid !== 1'b1 || e_data_in !== 8'h05) begin
      errors++; $display("FAIL single_load busy=%b owner=%b e_s_valid=%b e_data_in=%h want 1/0/1/05",
                         busy, owner, e_s_valid, e_data_in);
    end
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (want_idle) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL single_busy_fall got %b want 0", busy);
        end
        done = 1'b1;
        break;
      end
      checks++;
      if (m_valid_1 !== 1'b0) begin
        errors++; $display("FAIL single_m_valid_1 got %b want 0", m_valid_1);
      end
      if (m_valid_0 && m_ready_0) begin
        nout++;
        if (nout == M) begin
          want_idle = 1'b1;
          checks++;
          if (busy !== 1'b1) begin
            errors++; $display("FAIL single_busy_before_last got %b want 1", busy);
          end
        end
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL single_timeout outputs got %0d want %0d", nout, M);
    end
    checks++;
    if (obs_eng.size() != exp_eng.size() || obs_out0.size() != exp_out0.size() || obs_out1.size() != exp_out1.size()) begin
      errors++; $display("FAIL single_counts got %0d/%0d/%0d want %0d/%0d/%0d", obs_eng.size(), obs_out0.size(),
                         obs_out1.size(), exp_eng.size(), exp_out0.size(), exp_out1.size());
    end
    while (exp_eng.size() > 0 && obs_eng.size() > 0) begin
      e = exp_eng.pop_front(); o = obs_eng.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL single_eng_word got %h want %h", o, e); end
    end
    while (exp_out0.size() > 0 && obs_out0.size() > 0) begin
      e = exp_out0.pop_front(); o = obs_out0.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL single_out0_word got %h want %h", o, e); end
    end
  endtask

  task automatic test_simultaneous();
    logic [T-1:0] e, o;
    logic [T-1:0] aw [4];
    logic [T-1:0] bw [2];
    logic [T-1:0] rr [6];
    logic own_exp [3];
    logic got[$];
    int ai = 0, bi = 0, gap = 0;
    bit prev = 1'b0, seen = 1'b0, done = 1'b0;
    aw = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    bw = '{8'hB1, 8'hB2};
    rr = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
`ifdef MVM_ARB_FIXED_PRI_EN
    own_exp = '{1'b0, 1'b0, 1'b1};
`else
    own_exp = '{1'b0, 1'b1, 1'b0};
`endif
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    clear_sb();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) load0(aw[i]);
    for (int i = 0; i < 2; i++) load1(bw[i]);
    for (int f = 0; f < 3; f++) begin
      if (own_exp[f] == 1'b0) begin
        add_service(0, aw[ai], aw[ai + 1], rr[2 * f], rr[2 * f + 1]); ai += 2;
      end else begin
        add_service(1, bw[bi], bw[bi + 1], rr[2 * f], rr[2 * f + 1]); bi += 2;
      end
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy && !prev) begin
        got.push_back(owner);
        if (seen) begin
          checks++;
          if (gap !== 1) begin errors++; $display("FAIL simul_idle_gap got %0d want 1", gap); end
        end
        seen = 1'b1;
      end
      gap = busy ? 0 : gap + 1;
      prev = busy;
      if (busy) begin
        checks++;
        if ((owner == 1'b0 && (s_ready_1 !== 1'b0 || m_valid_1 !== 1'b0)) ||
            (owner == 1'b1 && (s_ready_0 !== 1'b0 || m_valid_0 !== 1'b0))) begin
          errors++; $display("FAIL simul_non_owner owner=%b s_ready=%b%b m_valid=%b%b want non-owner 0",
                             owner, s_ready_1, s_ready_0, m_valid_1, m_valid_0);
        end
      end
      if ((obs_out0.size() + obs_out1.size()) >= 6 && !busy) begin done = 1'b1; break; end
    end
    checks++;
    if (!done || got.size() != 3) begin
      errors++; $display("FAIL simul_frames got %0d frames want 3", got.size());
    end
    for (int f = 0; f < 3 && f < got.size(); f++) begin
      checks++;
      if (got[f] !== own_exp[f]) begin
        errors++; $display("FAIL simul_owner frame %0d got %b want %b", f, got[f], own_exp[f]);
      end
    end
    checks++;
    if (obs_eng.size() != exp_eng.size() || obs_out0.size() != exp_out0.size() || obs_out1.size() != exp_out1.size()) begin
      errors++; $display("FAIL simul_counts got %0d/%0d/%0d want %0d/%0d/%0d", obs_eng.size(), obs_out0.size(),
                         obs_out1.size(), exp_eng.size(), exp_out0.size(), exp_out1.size());
    end
    while (exp_eng.size() > 0 && obs_eng.size() > 0) begin
      e = exp_eng.pop_front(); o = obs_eng.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL simul_eng_word got %h want %h", o, e); end
    end
    while (exp_out0.size() > 0 && obs_out0.size() > 0) begin
      e = exp_out0.pop_front(); o = obs_out0.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL simul_out0_word got %h want %h", o, e); end
    end
    while (exp_out1.size() > 0 && obs_out1.size() > 0) begin
      e = exp_out1.pop_front(); o = obs_out1.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL simul_out1_word got %h want %h", o, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [T-1:0] e, o;
    bit ok = 1'b0, seen = 1'b0;
    clear_sb();
    rdy0 = 1'b0;
    @(posedge clk); #1;
    load0(8'h05); load0(8'h03);
    add_service(0, 8'h05, 8'h03, 8'h11, 8'h22);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid_0) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL bp_timeout m_valid_0 got 0 want 1"); end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (data_out_0 !== 8'h11 || e_m_ready !== 1'b0 || m_valid_0 !== 1'b1) begin
        errors++; $display("FAIL bp_hold cycle %0d data_out_0=%h e_m_ready=%b m_valid_0=%b want 11/0/1",
                           c, data_out_0, e_m_ready, m_valid_0);
      end
    end
    rdy0 = 1'b1;
    wait_outputs(2, 30, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_drain_timeout outputs got %0d want 2", obs_out0.size()); end
    checks++;
    if (obs_out0.size() != 2 || obs_out1.size() != 0) begin
      errors++; $display("FAIL bp_word_count got %0d/%0d want 2/0", obs_out0.size(), obs_out1.size());
    end
    while (exp_out0.size() > 0 && obs_out0.size() > 0) begin
      e = exp_out0.pop_front(); o = obs_out0.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL bp_out0_word got %h want %h", o, e); end
    end
  endtask

  task automatic test_stall();
    logic [T-1:0] e, o;
    bit ok = 1'b0, seen = 1'b0;
    clear_sb();
    @(posedge clk); #1;
    load0(8'h05);
    add_service(0, 8'h05, 8'h03, 8'h11, 8'h22);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (obs_eng.size() == 1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_timeout eng words got %0d want 1", obs_eng.size()); end
    load1(8'h77); load1(8'h88);
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (dut.in_cnt !== 2'd1 || dut.state !== LOAD || s_ready_1 !== 1'b0 || e_s_valid !== 1'b0) begin
        errors++; $display("FAIL stall_hold cycle %0d in_cnt=%0d state=%0d s_ready_1=%b e_s_valid=%b want 1/1/0/0",
                           c, dut.in_cnt, dut.state, s_ready_1, e_s_valid);
      end
    end
    load0(8'h03);
    add_service(1, 8'h77, 8'h88, 8'h33, 8'h44);
    wait_outputs(4, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_drain_timeout outputs got %0d want 4", obs_out0.size() + obs_out1.size()); end
    checks++;
    if (obs_eng.size() != exp_eng.size() || obs_out0.size() != exp_out0.size() || obs_out1.size() != exp_out1.size()) begin
      errors++; $display("FAIL stall_counts got %0d/%0d/%0d want %0d/%0d/%0d", obs_eng.size(), obs_out0.size(),
                         obs_out1.size(), exp_eng.size(), exp_out0.size(), exp_out1.size());
    end
    while (exp_eng.size() > 0 && obs_eng.size() > 0) begin
      e = exp_eng.pop_front(); o = obs_eng.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL stall_eng_word got %h want %h", o, e); end
    end
    while (exp_out1.size() > 0 && obs_out1.size() > 0) begin
      e = exp_out1.pop_front(); o = obs_out1.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL stall_out1_word got %h want %h", o, e); end
    end
  endtask

  task automatic test_spurious();
    logic [T-1:0] e, o;
    bit ok = 1'b0, seen = 1'b0;
    clear_sb();
    spur = 1'b1;
    @(negedge clk);
    checks++;
    if (e_m_ready !== 1'b0 || m_valid_0 !== 1'b0 || m_valid_1 !== 1'b0) begin
      errors++; $display("FAIL spur_idle e_m_ready=%b m_valid=%b%b want 0/00", e_m_ready, m_valid_1, m_valid_0);
    end
    @(posedge clk); #1;
    load0(8'h05);
    add_service(0, 8'h05, 8'h03, 8'h11, 8'h22);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (obs_eng.size() == 1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL spur_timeout eng words got %0d want 1", obs_eng.size()); end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (e_m_ready !== 1'b0 || m_valid_0 !== 1'b0 || m_valid_1 !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL spur_load cycle %0d e_m_ready=%b m_valid=%b%b busy=%b want 0/00/1",
                           c, e_m_ready, m_valid_1, m_valid_0, busy);
      end
    end
    spur = 1'b0;
    load0(8'h03);
    wait_outputs(2, 40, ok);
    checks++;
    if (!ok || obs_out0.size() != 2 || obs_out1.size() != 0) begin
      errors++; $display("FAIL spur_word_count got %0d/%0d want 2/0", obs_out0.size(), obs_out1.size());
    end
    while (exp_out0.size() > 0 && obs_out0.size() > 0) begin
      e = exp_out0.pop_front(); o = obs_out0.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL spur_out0_word got %h want %h", o, e); end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [T-1:0] e, o;
    bit ok = 1'b0, seen = 1'b0;
    clear_sb();
    @(posedge clk); #1;
    load0(8'h05); load0(8'h03);
    add_service(0, 8'h05, 8'h03, 8'h11, 8'h22);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (obs_out0.size() == 1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_mid_timeout outputs got %0d want 1", obs_out0.size()); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, owner, s_ready_0, s_ready_1, m_valid_0, m_valid_1, e_s_valid, e_m_ready} !== 8'h00 ||
        data_out_0 !== 8'h00) begin
      errors++; $display("FAIL rst_mid_outputs got %b data_out_0=%h want 00000000/00",
                         {busy, owner, s_ready_0, s_ready_1, m_valid_0, m_valid_1, e_s_valid, e_m_ready}, data_out_0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    clear_sb();
    @(posedge clk); #1;
    load0(8'hC1); load0(8'hC2);
    load1(8'hD1); load1(8'hD2);
    add_service(0, 8'hC1, 8'hC2, 8'h55, 8'h66);
    add_service(1, 8'hD1, 8'hD2, 8'h77, 8'h99);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || owner !== 1'b0) begin
      errors++; $display("FAIL rst_mid_grant busy=%b owner=%b want 1/0", busy, owner);
    end
    wait_outputs(4, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_mid_drain_timeout outputs got %0d want 4", obs_out0.size() + obs_out1.size()); end
    while (exp_out0.size() > 0 && obs_out0.size() > 0) begin
      e = exp_out0.pop_front(); o = obs_out0.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rst_mid_out0_word got %h want %h", o, e); end
    end
    while (exp_out1.size() > 0 && obs_out1.size() > 0) begin
      e = exp_out1.pop_front(); o = obs_out1.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rst_mid_out1_word got %h want %h", o, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_stall();
    test_spurious();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
